// File: rtl/block_shuffle_iter.sv
// Iterative Boron nibble shuffle over LANES x 16-bit lanes, one round per clock.
// Optional macro BLOCK_SHUFFLE_LANE_ROTATE_EN adds a per-round lane rotation.
module block_shuffle_iter #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ROUNDS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [16*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*LANES-1:0]   out_data,
    output logic                  out_mode,
    output logic                  busy
);

    localparam int unsigned W  = 16 * LANES;
    localparam int unsigned CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    if (ROUNDS < 1) begin : g_rounds_chk
        $error("block_shuffle_iter: ROUNDS must be >= 1");
    end
    if (LANES < 1) begin : g_lanes_chk
        $error("block_shuffle_iter: LANES must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    // Encrypt: e3=n1, e2=n3, e1=n0, e0=n2
    function automatic logic [15:0] enc_lane(input logic [15:0] n);
        return {n[7:4], n[15:12], n[3:0], n[11:8]};
    endfunction

    // Decrypt: d3=n2, d2=n0, d1=n3, d0=n1
    function automatic logic [15:0] dec_lane(input logic [15:0] n);
        return {n[11:8], n[3:0], n[15:12], n[7:4]};
    endfunction

    function automatic logic [W-1:0] round_fn(input logic [W-1:0] x, input logic dec);
        logic [W-1:0] src;
        logic [W-1:0] res;
        src = x;
`ifdef BLOCK_SHUFFLE_LANE_ROTATE_EN
        // Decrypt undoes the encrypt rotation first, so lane i takes lane i+1.
        if (dec) begin
            for (int unsigned i = 0; i < LANES; i++)
                src[16*i +: 16] = x[16*((i + 1) % LANES) +: 16];
        end
`endif
        for (int unsigned i = 0; i < LANES; i++)
            res[16*i +: 16] = dec ? dec_lane(src[16*i +: 16]) : enc_lane(src[16*i +: 16]);
`ifdef BLOCK_SHUFFLE_LANE_ROTATE_EN
        if (!dec) begin
            src = res;
            for (int unsigned i = 0; i < LANES; i++)
                res[16*i +: 16] = src[16*((i + LANES - 1) % LANES) +: 16];
        end
`endif
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        mode_d      = mode_q;
        rcnt_d      = rcnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d     = in_data;
                    mode_d     = in_mode;
                    rcnt_d     = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                data_d = round_fn(data_q, mode_q);
                rcnt_d = rcnt_q + CW'(1);
                if (rcnt_q == LAST) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            mode_q      <= 1'b0;
            rcnt_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            rcnt_q      <= rcnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;
    assign busy      = busy_q;

endmodule

// File: doc/block_shuffle_iter.md
Name: block_shuffle_iter

Overview:
Parametrised, iterative successor to the combinational 64-bit decryption block shuffle. It splits a LANES×16-bit block into 16-bit lanes and applies the Boron nibble shuffle (encrypt) or its inverse (decrypt) for ROUNDS iterations, one round per clock. It sits between the round-key XOR and S-box stages of the Boron datapath. Valid/ready handshakes on both sides provide back-pressure.

Parameters:
LANES, 4, number of 16-bit lanes; data width W = 16*LANES; must be ≥1.
ROUNDS, 1, shuffle iterations per block; must be ≥1, and ROUNDS=0 is an elaboration error.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input block present.
in_ready  output  1  block accepted on a clk edge when in_valid && in_ready.
in_mode  input  1  0 = encrypt shuffle, 1 = decrypt (inverse) shuffle; sampled at accept.
in_data  input  W  block; lane i = in_data[16i+15:16i].
out_valid  output  1  result present.
out_ready  input  1  consumer accepts when out_valid && out_ready.
out_data  output  W  shuffled block.
out_mode  output  1  mode the block was processed with.
busy  output  1  high in RUN or DONE.

Behaviour:
- Lane nibbles n3..n0, with n0 = bits[3:0].
- Encrypt round, result nibbles e3..e0: e0=n2, e1=n0, e2=n3, e3=n1. Example: 0x1234 -> 0x3142.
- Decrypt round, exact inverse: d0=n1, d1=n3, d2=n0, d3=n2. Example: 0x3142 -> 0x1234.
- The permutation has order 4, so 4 rounds in either mode equal the identity.
- FSM states: IDLE, RUN, DONE. Registers: data_q[W], mode_q, rcnt[$clog2(ROUNDS+1)].
- IDLE: in_ready=1. On accept: data_q<=in_data, mode_q<=in_mode, rcnt<=0, go to RUN.
- RUN: in_ready=0. Each edge: data_q<=round(data_q, mode_q) and rcnt<=rcnt+1. When rcnt==ROUNDS-1 at the edge, go to DONE.
- DONE: out_valid=1; out_data=data_q and out_mode=mode_q, held stable until out_ready. On handshake go to IDLE.
- No input acceptance outside IDLE. Throughput is one block per ROUNDS+2 cycles with no output stall.
- Latency: out_valid rises exactly ROUNDS edges after the accepting edge.
- in_data, in_mode and in_valid changes during RUN/DONE are ignored.
- out_ready held high before DONE has no effect.
- Reset values: state=IDLE, in_ready=1 (the first cycle after reset is accept-capable), out_valid=0, out_data=0, out_mode=0, busy=0, rcnt=0.
- Reset asserted mid-RUN or in DONE discards the block; no out_valid is produced for it.
- Reset has priority over any handshake in the same cycle.
- out_data is a direct register output: no combinational path from in_* to out_*.

Optional Feature:
Macro BLOCK_SHUFFLE_LANE_ROTATE_EN.
- Defined: each round also rotates lanes. Encrypt: result lane i moves to lane (i+1) mod LANES, applied after the nibble shuffle. Decrypt: lane i moves to (i-1) mod LANES before the inverse nibble shuffle. Decrypt remains the exact inverse of encrypt for any ROUNDS.
- Undefined: lanes are shuffled independently in place; no rotation logic is synthesised.

Test Plan:
- LANES=4, ROUNDS=1, mode=0, in_data=0x1234_5678_9ABC_DEF0 -> out_data=0x3142_7586_B9CA_FD0E, out_valid 1 cycle after accept, out_mode=0.
- Same configuration, mode=1, in_data=0x3142_7586_B9CA_FD0E -> out_data=0x1234_5678_9ABC_DEF0.
- ROUNDS=4, either mode, in_data=0x1234_5678_9ABC_DEF0 -> out_data equals in_data; out_valid rises 4 edges after accept.
- out_ready held 0 for 5 cycles in DONE -> out_data/out_valid stable; in_ready=0 throughout and a concurrent in_valid block is not taken; it is accepted the cycle after the output handshake.
- rst pulsed for 1 cycle mid-RUN (ROUNDS=3) -> no out_valid for that block; all outputs return to their reset values; the next block is processed correctly.
- With BLOCK_SHUFFLE_LANE_ROTATE_EN, ROUNDS=1, mode=0, 0x1234_5678_9ABC_DEF0 -> 0x7586_B9CA_FD0E_3142. Decrypting that value -> the original block.
